// File: rtl/ysyx_2022040010_axi_arbiter_pkg.sv
// Purpose : shared types and constants for the cache-to-AXI arbiter slice
// Latency : n/a (declarations only)
// Backpressure: n/a
// Contents: FSM state encoding, AXI response codes, requestor port indices.
package ysyx_2022040010_axi_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_AR  = 3'd1,
    ST_RD_R   = 3'd2,
    ST_WR_AWW = 3'd3,
    ST_WR_B   = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  // Any response with bit 1 set (SLVERR/DECERR) is reported as an error.
  localparam int         RESP_ERR_BIT = 1;

  localparam int PORT_ICACHE  = 0;
  localparam int PORT_DCACHE  = 1;
  localparam int PORT_UNCACHE = 2;

  // Width of a port index; a single port still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ysyx_2022040010_rr_arbiter.sv
// Purpose : picks one requestor, round-robin from a rotating pointer or fixed lowest-index priority
// Latency : combinational grant; pointer updates on the clock edge that takes the grant
// Backpressure: none; the caller decides when a grant is consumed via advance
// Ports: clk/rst (async active-low); req N-bit request; advance consumes the grant;
//        gnt one-hot grant, gnt_idx its index, gnt_any set when any request is present.
module ysyx_2022040010_rr_arbiter #(
  parameter int N          = 3,
  parameter int FIXED_PRIO = 0,
  parameter int IDX_W      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] cand_idx;
  int               cand;

  // Fixed priority is round-robin with the search always starting at port 0.
  assign base = (FIXED_PRIO != 0) ? '0 : ptr;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 0; off < N; off++) begin
      cand = int'(base) + off;
      if (cand >= N) cand = cand - N;
      cand_idx = cand[IDX_W-1:0];
      if (!gnt_any && req[cand_idx]) begin
        gnt_any       = 1'b1;
        gnt_idx       = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance && gnt_any) begin
      ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_2022040010_axi_arbiter.sv
// Purpose : arbitrates icache/dcache/uncache refill requests onto one AXI4-lite style master
// Latency : zero-wait slave gives rsp_valid_o three edges after the accept edge; one transaction in flight
// Backpressure: requestors hold req_valid_i until req_ready_o; AXI valids held until the slave handshakes
// Ports: clk/rst (async active-low); req_* packed per-port request; rsp_* owner-routed completion;
//        stallreq_o pipeline stall; ar/r/aw/w/b AXI master channels (ID = granted port index).
module ysyx_2022040010_axi_arbiter
  import ysyx_2022040010_axi_arbiter_pkg::*;
#(
  parameter int N_PORTS    = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 64,
  parameter int ID_W       = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          req_valid_i,
  output logic [N_PORTS-1:0]          req_ready_o,
  input  logic [N_PORTS-1:0]          req_we_i,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr_i,
  input  logic [N_PORTS*DATA_W-1:0]   req_wdata_i,
  input  logic [N_PORTS*DATA_W/8-1:0] req_mask_i,
  output logic [N_PORTS-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic                        rsp_err_o,
  output logic                        stallreq_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
  output logic [ID_W-1:0]             ar_id_o,
  output logic [ADDR_W-1:0]           ar_addr_o,
  input  logic                        r_valid_i,
  output logic                        r_ready_o,
  input  logic [ID_W-1:0]             r_id_i,
  input  logic [DATA_W-1:0]           r_data_i,
  input  logic [1:0]                  r_resp_i,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [ID_W-1:0]             aw_id_o,
  output logic [ADDR_W-1:0]           aw_addr_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  output logic [DATA_W-1:0]           w_data_o,
  output logic [DATA_W/8-1:0]         w_strb_o,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  input  logic [ID_W-1:0]             b_id_i,
  input  logic [1:0]                  b_resp_i
);

  localparam int IDX_W  = idx_width(N_PORTS);
  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              we;
    logic [IDX_W-1:0]  owner;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } txn_t;

  state_e state, state_nxt;
  txn_t   txn;

  logic [N_PORTS-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               take_grant;

  logic [ID_W-1:0]    owner_id;
  logic               ar_hs, r_hit, aw_hs, w_hs, b_hs;
  logic               aw_done, w_done;

  logic [N_PORTS-1:0] req_ready_nxt, rsp_valid_nxt;
  logic [DATA_W-1:0]  rsp_rdata_nxt;
  logic               rsp_err_nxt;
  logic               ar_valid_nxt, r_ready_nxt, aw_valid_nxt, w_valid_nxt, b_ready_nxt;
  logic               aw_done_nxt, w_done_nxt;
  logic               unused_ok;

  // B carries no payload to check against the owner; only one write is ever in flight.
  assign unused_ok = ^{r_resp_i[0], b_resp_i[0], b_id_i};

  assign take_grant = (state == ST_IDLE) && gnt_any;

  ysyx_2022040010_rr_arbiter #(
    .N          (N_PORTS),
    .FIXED_PRIO (FIXED_PRIO),
    .IDX_W      (IDX_W)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid_i),
    .advance (take_grant),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign owner_id = ID_W'(txn.owner);
  assign ar_hs    = ar_valid_o && ar_ready_i;
  // Beats for other IDs are still accepted (r_ready_o high) but never completed.
  assign r_hit    = r_valid_i && r_ready_o && (r_id_i == owner_id);
  assign aw_hs    = aw_valid_o && aw_ready_i;
  assign w_hs     = w_valid_o && w_ready_i;
  assign b_hs     = b_valid_i && b_ready_o;

  assign stallreq_o = (|req_valid_i) || (state != ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (gnt_any) state_nxt = req_we_i[gnt_idx] ? ST_WR_AWW : ST_RD_AR;
      ST_RD_AR:  if (ar_hs) state_nxt = ST_RD_R;
      ST_RD_R:   if (r_hit) state_nxt = ST_IDLE;
      ST_WR_AWW: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = ST_WR_B;
      ST_WR_B:   if (b_hs) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    req_ready_nxt = '0;
    rsp_valid_nxt = '0;
    rsp_rdata_nxt = rsp_rdata_o;
    rsp_err_nxt   = rsp_err_o;
    if (state == ST_IDLE) req_ready_nxt = gnt_oh;

    // The request channel sits low for the first cycle in the new state, so
    // every AXI valid rises the cycle after req_ready_o.
    ar_valid_nxt = (state == ST_RD_AR) && (state_nxt == ST_RD_AR);
    r_ready_nxt  = (state_nxt == ST_RD_R);

    aw_done_nxt  = (state == ST_WR_AWW) && (aw_done || aw_hs);
    w_done_nxt   = (state == ST_WR_AWW) && (w_done || w_hs);
    aw_valid_nxt = (state == ST_WR_AWW) && (state_nxt == ST_WR_AWW) && !aw_done_nxt;
    w_valid_nxt  = (state == ST_WR_AWW) && (state_nxt == ST_WR_AWW) && !w_done_nxt;
    b_ready_nxt  = (state_nxt == ST_WR_B);

    if ((state == ST_RD_R) && r_hit) begin
      rsp_valid_nxt[txn.owner] = 1'b1;
      rsp_rdata_nxt            = r_data_i;
      rsp_err_nxt              = r_resp_i[RESP_ERR_BIT];
    end
    if ((state == ST_WR_B) && b_hs) begin
      rsp_valid_nxt[txn.owner] = 1'b1;
      rsp_rdata_nxt            = '0;
      rsp_err_nxt              = b_resp_i[RESP_ERR_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready_o <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      ar_valid_o  <= 1'b0;
      r_ready_o   <= 1'b0;
      aw_valid_o  <= 1'b0;
      w_valid_o   <= 1'b0;
      b_ready_o   <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      req_ready_o <= req_ready_nxt;
      rsp_valid_o <= rsp_valid_nxt;
      rsp_rdata_o <= rsp_rdata_nxt;
      rsp_err_o   <= rsp_err_nxt;
      ar_valid_o  <= ar_valid_nxt;
      r_ready_o   <= r_ready_nxt;
      aw_valid_o  <= aw_valid_nxt;
      w_valid_o   <= w_valid_nxt;
      b_ready_o   <= b_ready_nxt;
      aw_done     <= aw_done_nxt;
      w_done      <= w_done_nxt;
    end
  end

  // Request is captured at grant so the requestor may withdraw right after accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txn <= '0;
    end else if (take_grant) begin
      txn.we    <= req_we_i[gnt_idx];
      txn.owner <= gnt_idx;
      txn.addr  <= req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
      txn.wdata <= req_wdata_i[gnt_idx*DATA_W +: DATA_W];
      txn.strb  <= req_mask_i[gnt_idx*STRB_W +: STRB_W];
    end
  end

  assign ar_id_o   = owner_id;
  assign ar_addr_o = txn.addr;
  assign aw_id_o   = owner_id;
  assign aw_addr_o = txn.addr;
  assign w_data_o  = txn.wdata;
  assign w_strb_o  = txn.strb;

endmodule
